// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state types and bit-timing helpers for uart_alloc
//
// Purpose: one place for the RX/TX state encodings and the clocks-per-bit math
// so the top level and the transmitter agree on bit timing.
// Contents:
//   rx_state_t     receive FSM states
//   tx_state_t     transmit FSM states
//   clks_per_bit() CLK_HZ / BIT_RATE (integer division)
//   cnt_width()    width of a counter that spans 0 .. clks_per_bit-1
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_ARMED = 3'd1,
        RX_START = 3'd2,
        RX_DATA  = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // $clog2(n) bits hold 0 .. n-1; keep at least one bit for degenerate rates.
    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with valid/ready byte intake
//
// Purpose: serialises one byte per handshake as start(0), 8 data bits LSB
// first, stop(1); every bit is held for exactly CLKS_PER_BIT cycles.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   valid  out  transmitter idle and able to accept a byte
//   ready  in   client offers data for transmission
//   data   in   byte to transmit, latched on the handshake edge
//   line   out  serial TX line, idles high
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       valid,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       line
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shreg, shreg_next;
    logic             line_q, line_next;
    logic             bit_done;

    assign bit_done = (cnt == CNT_LAST);
    assign valid    = (state == TX_IDLE);
    assign line     = line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            line_q  <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
            line_q  <= line_next;
        end
    end

    // The line is registered so the start bit appears the cycle after the
    // handshake edge and each level change lines up with a bit boundary.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shreg_next = shreg;
        line_next  = line_q;
        case (state)
            TX_IDLE: begin
                cnt_next  = '0;
                line_next = 1'b1;
                if (ready) begin
                    state_next = TX_START;
                    shreg_next = data;
                    bit_next   = '0;
                    line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    state_next = TX_DATA;
                    cnt_next   = '0;
                    line_next  = shreg[0];
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = TX_STOP;
                        line_next  = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shreg_next = {1'b0, shreg[7:1]};
                        line_next  = shreg[1];
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    state_next = TX_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = TX_IDLE;
                cnt_next   = '0;
                line_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_alloc.sv
// rtl/uart_alloc.sv - UART endpoint: armed 8N1 receiver, 8N1 transmitter, clock/reset forward
//
// Purpose: one instance gives a client block its clock, reset and a serial
// byte interface in each direction.
// Ports:
//   clk_i, aresetn_i     system clock, asynchronous active-low reset
//   clk_o, aresetn_o     combinational copies of clk_i / aresetn_i
//   s_valid_i, s_ready_o arm request / receiver idle
//   s_rx_data_i          serial RX line (idles high)
//   s_rx_data_o          last correctly framed received byte
//   m_valid_o, m_ready_i transmitter idle / client offers a byte
//   m_tx_data_i          byte to transmit
//   m_tx_data_o          serial TX line (idles high)
module uart_alloc
    import uart_pkg::*;
#(
    parameter int BIT_RATE = 9600,
    parameter int CLK_HZ   = 100_000_000
) (
    input  logic       clk_i,
    input  logic       aresetn_i,
    output logic       clk_o,
    output logic       aresetn_o,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  logic       s_rx_data_i,
    output logic [7:0] s_rx_data_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic       m_tx_data_o,
    input  logic [7:0] m_tx_data_i
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BIT_RATE);
    localparam int CNT_W        = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    assign clk_o     = clk_i;
    assign aresetn_o = aresetn_i;

    // Two-flop synchronizer; reset to the idle-high level so reset release
    // never looks like a start bit.
    logic [1:0] sync;
    logic       rx_s;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], s_rx_data_i};
        end
    end

    assign rx_s = sync[1];

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shreg, shreg_next;
    logic [7:0]       data_q, data_next;
    logic             bit_done;

    assign bit_done    = (cnt == CNT_LAST);
    assign s_ready_o   = (state == RX_IDLE);
    assign s_rx_data_o = data_q;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
            data_q  <= data_next;
        end
    end

    // START waits half a bit so every later full-bit sample lands mid-bit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shreg_next = shreg;
        data_next  = data_q;
        case (state)
            RX_IDLE: begin
                cnt_next = '0;
                if (s_valid_i) begin
                    state_next = RX_ARMED;
                end
            end
            RX_ARMED: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    bit_next = '0;
                    // A line back high at mid start bit was a glitch: re-arm.
                    state_next = rx_s ? RX_ARMED : RX_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    // A low stop bit is a framing error; the byte is dropped.
                    if (rx_s) begin
                        data_next = shreg;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = RX_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_tx (
        .clk   (clk_i),
        .rst_n (aresetn_i),
        .valid (m_valid_o),
        .ready (m_ready_i),
        .data  (m_tx_data_i),
        .line  (m_tx_data_o)
    );

endmodule

// File: tb/tb_uart_alloc.sv
// tb/tb_uart_alloc.sv - self-checking bench for uart_alloc
module tb_uart_alloc;

    localparam int BIT_RATE = 9600;
    localparam int CLK_HZ   = 153_600;
    localparam int CPB      = CLK_HZ / BIT_RATE;

    logic       clk;
    logic       rst_n;
    logic       clk_o;
    logic       aresetn_o;
    logic       s_valid_i;
    logic       s_ready_o;
    logic       s_rx_data_i;
    logic [7:0] s_rx_data_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic       m_tx_data_o;
    logic [7:0] m_tx_data_i;

    int checks;
    int failures;

    uart_alloc #(
        .BIT_RATE (BIT_RATE),
        .CLK_HZ   (CLK_HZ)
    ) dut (
        .clk_i       (clk),
        .aresetn_i   (rst_n),
        .clk_o       (clk_o),
        .aresetn_o   (aresetn_o),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_rx_data_i (s_rx_data_i),
        .s_rx_data_o (s_rx_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_tx_data_o (m_tx_data_o),
        .m_tx_data_i (m_tx_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        s_rx_data_i = 1'b0;
        wait_cycles(CPB);
        for (int b = 0; b < 8; b++) begin
            s_rx_data_i = d[b];
            wait_cycles(CPB);
        end
        s_rx_data_i = stop;
        wait_cycles(CPB);
        s_rx_data_i = 1'b1;
    endtask

    task automatic arm;
        s_valid_i = 1'b1;
        @(negedge clk);
        s_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        s_valid_i   = 1'b0;
        s_rx_data_i = 1'b1;
        m_ready_i   = 1'b0;
        m_tx_data_i = 8'h00;
        wait_cycles(3);
        checks++;
        if (aresetn_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_aresetn_o_low got=%b exp=0", aresetn_o);
        end
        rst_n = 1'b1;
        wait_cycles(2);
        checks++;
        if (aresetn_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_aresetn_o_high got=%b exp=1", aresetn_o);
        end
        checks++;
        if (m_tx_data_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx_line got=%b exp=1", m_tx_data_o);
        end
        checks++;
        if (s_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready got=%b exp=1", s_ready_o);
        end
        checks++;
        if (m_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_m_valid got=%b exp=1", m_valid_o);
        end
        checks++;
        if (s_rx_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_rx_data got=%h exp=00", s_rx_data_o);
        end
        checks++;
        if (clk_o !== 1'b0) begin
            failures++;
            $display("FAIL clk_o_low got=%b exp=0", clk_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (clk_o !== 1'b1) begin
            failures++;
            $display("FAIL clk_o_high got=%b exp=1", clk_o);
        end
        @(negedge clk);
    endtask

    task automatic test_rx_armed;
        arm();
        checks++;
        if (s_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rx_armed_ready got=%b exp=0", s_ready_o);
        end
        send_frame(8'h81, 1'b1);
        wait_cycles(4);
        checks++;
        if (s_rx_data_o !== 8'h81) begin
            failures++;
            $display("FAIL rx_armed_data got=%h exp=81", s_rx_data_o);
        end
        checks++;
        if (s_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rx_armed_ready_back got=%b exp=1", s_ready_o);
        end
    endtask

    task automatic test_rx_second;
        arm();
        send_frame(8'h26, 1'b1);
        wait_cycles(4);
        checks++;
        if (s_rx_data_o !== 8'h26) begin
            failures++;
            $display("FAIL rx_second_data got=%h exp=26", s_rx_data_o);
        end
    endtask

    task automatic test_rx_unarmed;
        send_frame(8'h88, 1'b1);
        wait_cycles(4);
        checks++;
        if (s_rx_data_o !== 8'h26) begin
            failures++;
            $display("FAIL rx_unarmed_data got=%h exp=26", s_rx_data_o);
        end
        checks++;
        if (s_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rx_unarmed_ready got=%b exp=1", s_ready_o);
        end
    endtask

    task automatic test_rx_framing;
        arm();
        send_frame(8'h5A, 1'b0);
        wait_cycles(4);
        checks++;
        if (s_rx_data_o !== 8'h26) begin
            failures++;
            $display("FAIL rx_framing_data got=%h exp=26", s_rx_data_o);
        end
        checks++;
        if (s_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rx_framing_ready got=%b exp=1", s_ready_o);
        end
    endtask

    task automatic test_rx_glitch;
        arm();
        s_rx_data_i = 1'b0;
        wait_cycles(3);
        s_rx_data_i = 1'b1;
        wait_cycles(CPB);
        checks++;
        if (s_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rx_glitch_rearmed got=%b exp=0", s_ready_o);
        end
        send_frame(8'h3C, 1'b1);
        wait_cycles(4);
        checks++;
        if (s_rx_data_o !== 8'h3C) begin
            failures++;
            $display("FAIL rx_glitch_data got=%h exp=3c", s_rx_data_o);
        end
    endtask

    task automatic test_tx_continuous;
        logic [9:0] fr;
        logic       bad;
        logic       vbad;
        fr = {1'b1, 8'h9D, 1'b0};
        m_tx_data_i = 8'h9D;
        m_ready_i   = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            vbad = 1'b0;
            for (int b = 0; b < 10; b++) begin
                bad = 1'b0;
                for (int c = 0; c < CPB; c++) begin
                    if (m_tx_data_o !== fr[b]) bad = 1'b1;
                    if (m_valid_o !== 1'b0) vbad = 1'b1;
                    if (f == 0 && b == 2 && c == 0) m_tx_data_i = 8'h00;
                    if (f == 0 && b == 8 && c == 0) m_tx_data_i = 8'h9D;
                    if (f == 1 && b == 4 && c == 0) m_ready_i = 1'b0;
                    @(negedge clk);
                end
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL tx_bit frame=%0d bit=%0d got=%b exp=%b for %0d cycles",
                             f, b, m_tx_data_o, fr[b], CPB);
                end
            end
            checks++;
            if (vbad) begin
                failures++;
                $display("FAIL tx_valid_busy frame=%0d got=1 exp=0", f);
            end
            checks++;
            if (m_tx_data_o !== 1'b1 || m_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL tx_gap frame=%0d line=%b valid=%b exp=1,1", f, m_tx_data_o, m_valid_o);
            end
            @(negedge clk);
        end
        bad = 1'b0;
        for (int c = 0; c < 3 * CPB; c++) begin
            if (m_tx_data_o !== 1'b1 || m_valid_o !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL tx_throttle_idle line=%b valid=%b exp=1,1", m_tx_data_o, m_valid_o);
        end
    endtask

    task automatic test_reset_mid_frame;
        m_tx_data_i = 8'h00;
        m_ready_i   = 1'b1;
        @(negedge clk);
        m_ready_i = 1'b0;
        wait_cycles(2 * CPB + 3);
        checks++;
        if (m_tx_data_o !== 1'b0) begin
            failures++;
            $display("FAIL tx_pre_reset_bit got=%b exp=0", m_tx_data_o);
        end
        arm();
        s_rx_data_i = 1'b0;
        wait_cycles(CPB);
        s_rx_data_i = 1'b1;
        wait_cycles(4 * CPB);
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tx_data_o !== 1'b1 || m_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_tx line=%b valid=%b exp=1,1", m_tx_data_o, m_valid_o);
        end
        checks++;
        if (s_rx_data_o !== 8'h00 || s_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_rx data=%h ready=%b exp=00,1", s_rx_data_o, s_ready_o);
        end
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(6 * CPB);
        checks++;
        if (m_tx_data_o !== 1'b1 || s_rx_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_after line=%b data=%h exp=1,00", m_tx_data_o, s_rx_data_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_rx_armed();
        test_rx_second();
        test_rx_unarmed();
        test_rx_framing();
        test_rx_glitch();
        test_tx_continuous();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
